// File: rtl/clk_div_gen.sv
// Programmable integer clock divider: registered divided clock, rise/fall strobes,
// runtime divisor switching at period boundaries, run/stop control and lock flag.
module clk_div_gen #(
  parameter int unsigned DIV_W        = 8,
  parameter int unsigned DEFAULT_DIV  = 3,
  parameter int unsigned LOCK_PERIODS = 4
) (
  input  logic             clkin,
  input  logic             reset,
  input  logic             en,
  input  logic [DIV_W-1:0] div_i,
  input  logic             div_load,
  output logic             clkout,
  output logic             rise_stb,
  output logic             fall_stb,
  output logic             locked,
  output logic [DIV_W-1:0] div_cur
);

  localparam int unsigned LCK_W = $clog2(LOCK_PERIODS + 1);
  localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0] DIV_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};
  localparam logic [DIV_W-1:0] DIV_TWO  = {{(DIV_W-2){1'b0}}, 2'b10};
  localparam logic [DIV_W-1:0] DEF_DIV  = DIV_W'(DEFAULT_DIV);
  localparam logic [LCK_W-1:0] LCK_ZERO = {LCK_W{1'b0}};
  localparam logic [LCK_W-1:0] LCK_ONE  = {{(LCK_W-1){1'b0}}, 1'b1};
  localparam logic [LCK_W-1:0] LCK_MAX  = LCK_W'(LOCK_PERIODS);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Divisors below 2 cannot form a high and a low phase, so they become 2.
  function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
    if (d < DIV_TWO) begin
      clamp_div = DIV_TWO;
    end else begin
      clamp_div = d;
    end
  endfunction

  state_e           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_cur_q, div_cur_d;
  logic [DIV_W-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic [LCK_W-1:0] lock_cnt_q, lock_cnt_d;
  logic             clk_q, clk_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             locked_q, locked_d;

  logic [DIV_W-1:0] load_div_s;
  logic [DIV_W:0]   hi_len_s;
  logic [DIV_W:0]   cnt_nxt_s;
  logic             boundary_s;

  assign load_div_s = clamp_div(div_i);
  assign hi_len_s   = ({1'b0, div_cur_q} + {1'b0, DIV_ONE}) >> 1;
  assign cnt_nxt_s  = {1'b0, cnt_q} + {1'b0, DIV_ONE};
  assign boundary_s = (cnt_q == (div_cur_q - DIV_ONE));

  // Next-state and registered-output logic for the run/stop machine.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_cur_d  = div_cur_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    lock_cnt_d = lock_cnt_q;
    clk_d      = clk_q;
    rise_d     = 1'b0;
    fall_d     = 1'b0;
    locked_d   = locked_q;

    case (state_q)
      ST_IDLE: begin
        clk_d      = 1'b0;
        cnt_d      = DIV_ZERO;
        lock_cnt_d = LCK_ZERO;
        if (div_load) begin
          div_cur_d  = load_div_s;
          pend_vld_d = 1'b0;
        end else begin
          div_cur_d  = div_cur_q;
        end
        if (en) begin
          state_d = ST_RUN;
          clk_d   = 1'b1;
          rise_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (div_load) begin
          pend_d     = load_div_s;
          pend_vld_d = 1'b1;
        end else begin
          pend_d     = pend_q;
        end
        if (boundary_s) begin
          if (en) begin
            cnt_d  = DIV_ZERO;
            clk_d  = 1'b1;
            rise_d = 1'b1;
            // A load in the boundary cycle itself takes priority over the older pending value.
            if (div_load) begin
              div_cur_d  = load_div_s;
              pend_vld_d = 1'b0;
              lock_cnt_d = LCK_ZERO;
            end else if (pend_vld_q) begin
              div_cur_d  = pend_q;
              pend_vld_d = 1'b0;
              lock_cnt_d = LCK_ZERO;
            end else if (lock_cnt_q != LCK_MAX) begin
              lock_cnt_d = lock_cnt_q + LCK_ONE;
              if (lock_cnt_q == (LCK_MAX - LCK_ONE)) begin
                locked_d = 1'b1;
              end else begin
                locked_d = locked_q;
              end
            end else begin
              lock_cnt_d = lock_cnt_q;
            end
          end else begin
            state_d = ST_IDLE;
            cnt_d   = DIV_ZERO;
            clk_d   = 1'b0;
            fall_d  = (hi_len_s == {1'b0, div_cur_q});
          end
        end else begin
          cnt_d  = cnt_nxt_s[DIV_W-1:0];
          clk_d  = (cnt_nxt_s < hi_len_s);
          fall_d = (cnt_nxt_s == hi_len_s);
        end
      end
      default: begin
        state_d = ST_IDLE;
        clk_d   = 1'b0;
      end
    endcase

    // Lock count restarts too, so a brief en drop can re-lock after a fresh run of periods.
    if (!en || div_load) begin
      locked_d   = 1'b0;
      lock_cnt_d = LCK_ZERO;
    end else begin
      locked_d   = locked_d;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clkin) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= DIV_ZERO;
      div_cur_q  <= DEF_DIV;
      pend_q     <= DIV_ZERO;
      pend_vld_q <= 1'b0;
      lock_cnt_q <= LCK_ZERO;
      clk_q      <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_cur_q  <= div_cur_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      lock_cnt_q <= lock_cnt_d;
      clk_q      <= clk_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      locked_q   <= locked_d;
    end
  end

  assign clkout   = clk_q;
  assign rise_stb = rise_q;
  assign fall_stb = fall_q;
  assign locked   = locked_q;
  assign div_cur  = div_cur_q;

endmodule
